// File: rtl/mips_pkg.sv
// Definitions shared by the fetch stage and the decoder: branch-select codes,
// fetch states, reset PC default and primary opcodes.
package mips_pkg;

  localparam logic [1:0] BS_NONE = 2'b00;
  localparam logic [1:0] BS_COND = 2'b01;
  localparam logic [1:0] BS_JMR  = 2'b10;
  localparam logic [1:0] BS_JMP  = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } fetch_state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // PS selects the polarity: 0 branches on Z, 1 branches on !Z.
  function automatic logic take_branch(input logic [1:0] bs, input logic ps, input logic z);
    return bs[1] | ((bs == BS_COND) & (z ^ ps));
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with a single-cycle clear; count is the exact occupancy.
// Serves as both the pending-PC queue and the decoder-facing output buffer.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [WIDTH-1:0]        push_data,
  input  logic                    pop,
  input  logic                    clear,
  output logic [WIDTH-1:0]        rd_data,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != (PW+1)'(DEPTH)) || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage is zeroed on reset so the read port shows 0 until the first push.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, in-order imem requests, output buffer and branch redirect with
// stale-response discard. Define FETCH_PERF_EN to build the performance counters.
//
//   state   | meaning
//   S_RUN   | issuing requests, responses forwarded to the output buffer
//   S_FLUSH | no requests; drop_cnt stale responses still to be discarded
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                    INSTRUCTION_SIZE = 32,
  parameter int                    ADDR_WIDTH       = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC         = ADDR_WIDTH'(RESET_PC_DEFAULT),
  parameter int                    BUF_DEPTH        = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [ADDR_WIDTH-1:0]       imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] imem_rsp_data,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [ADDR_WIDTH-1:0]       instr_pc,
  input  logic                        br_valid,
  input  logic [1:0]                  BS,
  input  logic                        PS,
  input  logic                        Z,
  input  logic [ADDR_WIDTH-1:0]       br_target,
  output logic [31:0]                 perf_fetch_cnt,
  output logic [31:0]                 perf_flush_cnt
);

  localparam int             CW      = $clog2(BUF_DEPTH) + 1;
  localparam int             OW      = INSTRUCTION_SIZE + ADDR_WIDTH;
  localparam logic [CW:0]    DEPTH_W = (CW+1)'(BUF_DEPTH);

  fetch_state_e          state, state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [CW-1:0]         drop_cnt, drop_next, in_flight;
  logic [CW-1:0]         pend_count, out_count;
  logic [CW:0]           occupancy;
  logic                  redirect, req_fire, instr_fire;
  logic                  pend_pop, rsp_accept;
  logic [ADDR_WIDTH-1:0] pend_pc;
  logic [OW-1:0]         out_data;

  assign redirect      = br_valid & take_branch(BS, PS, Z);
  assign imem_req_addr = pc;
  assign req_fire      = imem_req_valid & imem_req_ready;
  assign instr_valid   = (out_count != '0);
  assign instr_fire    = instr_valid & instr_ready;
  assign pend_pop      = (state == S_RUN) & imem_rsp_valid;
  assign {instruction, instr_pc} = out_data;

  // A word leaving to the decoder this cycle frees its slot for a new request.
  assign occupancy = {1'b0, pend_count} + {1'b0, out_count} - {{CW{1'b0}}, instr_fire};

  always_comb begin
    imem_req_valid = 1'b0;
    rsp_accept     = 1'b0;
    state_next     = state;
    drop_next      = drop_cnt;
    in_flight      = (state == S_RUN) ? pend_count : drop_cnt;
    if (state == S_RUN) begin
      imem_req_valid = !rst && !redirect && (occupancy < DEPTH_W);
      rsp_accept     = imem_rsp_valid && !redirect;
    end
    if (redirect) begin
      drop_next  = in_flight - CW'(imem_rsp_valid);
      state_next = (drop_next != '0) ? S_FLUSH : S_RUN;
    end else if (state == S_FLUSH && imem_rsp_valid) begin
      drop_next = drop_cnt - 1'b1;
      if (drop_next == '0) state_next = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
      if (redirect)      pc <= br_target;
      else if (req_fire) pc <= pc + 1'b1;
    end
  end

  fetch_fifo #(.WIDTH(ADDR_WIDTH), .DEPTH(BUF_DEPTH)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .push      (req_fire),
    .push_data (pc),
    .pop       (pend_pop),
    .clear     (redirect),
    .rd_data   (pend_pc),
    .count     (pend_count)
  );

  fetch_fifo #(.WIDTH(OW), .DEPTH(BUF_DEPTH)) u_out (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_accept),
    .push_data ({imem_rsp_data, pend_pc}),
    .pop       (instr_fire),
    .clear     (redirect),
    .rd_data   (out_data),
    .count     (out_count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (instr_fire) perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (redirect)   perf_flush_cnt <= perf_flush_cnt + 1'b1;
    end
  end
`else
  assign perf_fetch_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: imem responder plus a queue-level model of what the
// decoder must see, decode table vectors, hand sequences and randomized traffic.
module tb_instr_fetch;

  localparam logic [31:0] RPC   = 32'h10;
  localparam int          DEPTH = 2;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid, instr_ready;
  logic [31:0] instruction, instr_pc;
  logic        br_valid;
  logic [1:0]  BS;
  logic        PS, Z;
  logic [31:0] br_target;
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;

  always #5 clk = ~clk;

  instr_fetch #(
    .INSTRUCTION_SIZE(32), .ADDR_WIDTH(32), .RESET_PC(RPC), .BUF_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc),
    .br_valid(br_valid), .BS(BS), .PS(PS), .Z(Z), .br_target(br_target),
    .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] data; logic [31:0] pc; } word_t;
  typedef struct { bit bv; logic [1:0] bs; bit ps; bit z; bit red; } vec_t;

  req_t        q[$];
  word_t       expq[$];
  vec_t        vt[9];
  logic [31:0] mpc;
  int          cyc = 0, lat = 1, gap_pct = 0;
  int          exp_fetch = 0, exp_flush = 0, passed = 0, total = 0;
  bit          last_rfire, last_ivalid, last_reqv;
  logic [31:0] last_addr, last_instr, last_pc;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: present imem response, sample at negedge, check, advance model.
  task automatic cycle();
    bit    rsp, red, rfire, ifire, flushing;
    req_t  r;
    rsp = 1'b0;
    if (q.size() > 0) begin
      if (q[0].due <= cyc && $urandom_range(99) >= gap_pct) rsp = 1'b1;
    end
    imem_rsp_valid = rsp;
    if (rsp) imem_rsp_data = memword(q[0].addr);
    else     imem_rsp_data = $urandom();
    @(negedge clk);
    red      = br_valid && (BS[1] || (BS == 2'b01 && Z != PS));
    rfire    = imem_req_valid && imem_req_ready;
    ifire    = instr_valid && instr_ready;
    flushing = 1'b0;
    foreach (q[i]) if (q[i].stale) flushing = 1'b1;
    last_rfire  = rfire;
    last_reqv   = imem_req_valid;
    last_addr   = imem_req_addr;
    last_ivalid = instr_valid;
    last_instr  = instruction;
    last_pc     = instr_pc;
    if (!rst) begin
      chk("perf_fetch", perf_fetch_cnt, PERF ? exp_fetch : 0);
      chk("perf_flush", perf_flush_cnt, PERF ? exp_flush : 0);
      chk("occupancy", (q.size() + expq.size()) <= DEPTH, 1);
      chk("instr_valid", instr_valid, expq.size() != 0);
      if (ifire && expq.size() != 0) begin
        chk("instruction", instruction, expq[0].data);
        chk("instr_pc", instr_pc, expq[0].pc);
        void'(expq.pop_front());
        exp_fetch++;
      end
      if (rfire) chk("req_addr", imem_req_addr, mpc);
      if (red || flushing) chk("req_suppressed", imem_req_valid, 0);
      if (rsp) begin
        r = q.pop_front();
        if (!r.stale && !red) expq.push_back('{memword(r.addr), r.addr});
      end
      if (rfire) begin
        q.push_back('{mpc, cyc + lat, 1'b0});
        mpc = mpc + 32'd1;
      end
      if (red) begin
        foreach (q[i]) q[i].stale = 1'b1;
        expq.delete();
        mpc = br_target;
        exp_flush++;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset(input int ncyc);
    rst = 1'b1; br_valid = 1'b0; instr_ready = 1'b1; imem_req_ready = 1'b1; gap_pct = 0;
    q.delete(); expq.delete(); mpc = RPC; exp_fetch = 0; exp_flush = 0;
    for (int i = 0; i < ncyc; i++) begin
      cycle();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instruction", instruction, 0);
      chk("rst_instr_pc", instr_pc, 0);
      chk("rst_perf", {perf_fetch_cnt, perf_flush_cnt}, 0);
    end
    rst = 1'b0;
  endtask

  task automatic wait_fire(input int bound, output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!last_rfire && n < bound);
    chk("wait_fire", last_rfire, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, delivered;
    bit          have;
    logic [31:0] held_i, held_pc, pc0, tgt;

    vt = '{'{1, 2'b00, 0, 0, 0}, '{1, 2'b01, 0, 1, 1}, '{1, 2'b01, 0, 0, 0},
           '{1, 2'b01, 1, 1, 0}, '{1, 2'b01, 1, 0, 1}, '{1, 2'b10, 0, 0, 1},
           '{1, 2'b11, 1, 1, 1}, '{0, 2'b11, 0, 0, 0}, '{0, 2'b01, 0, 1, 0}};
    rst = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1; br_valid = 1'b0;
    BS = 2'b00; PS = 1'b0; Z = 1'b0; br_target = '0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;

    // Sequential fetch from RESET_PC at latency 1.
    do_reset(2); lat = 1;
    cycle(); chk("t1_first_req", last_rfire, 1); chk("t1_addr0", last_addr, 32'h10);
    cycle(); chk("t1_second_req", last_rfire, 1); chk("t1_addr1", last_addr, 32'h11);
    cycle(); chk("t1_third_req", last_rfire, 1); chk("t1_addr2", last_addr, 32'h12);
    repeat (5) cycle();

    // Decoder stalled: only BUF_DEPTH requests, presented word held stable.
    do_reset(2); lat = 1; instr_ready = 1'b0; n = 0; have = 1'b0;
    held_i = '0; held_pc = '0;
    repeat (6) begin
      cycle();
      n += int'(last_rfire);
      if (last_ivalid) begin
        if (!have) begin
          have = 1'b1; held_i = last_instr; held_pc = last_pc;
        end else begin
          chk("t2_stable_instr", last_instr, held_i);
          chk("t2_stable_pc", last_pc, held_pc);
        end
      end
    end
    chk("t2_req_count", n, DEPTH);
    instr_ready = 1'b1;
    repeat (6) cycle();

    // Redirect decode table, one fresh run per vector.
    for (int i = 0; i < 9; i++) begin
      do_reset(2); lat = 1;
      repeat (5) cycle();
      pc0 = mpc;
      tgt = 32'h100 + 32'(i) * 32'h20;
      br_valid = vt[i].bv; BS = vt[i].bs; PS = vt[i].ps; Z = vt[i].z; br_target = tgt;
      cycle();
      chk("tbl_req_valid", last_reqv, !vt[i].red);
      br_valid = 1'b0;
      wait_fire(10, n);
      chk("tbl_next_addr", last_addr, vt[i].red ? tgt : pc0 + 32'd1);
      repeat (3) cycle();
    end

    // JMR with two requests in flight at latency 3: both dropped, then target.
    do_reset(2); lat = 3; n = 0;
    while (q.size() < 2 && n < 20) begin cycle(); n++; end
    chk("t5_two_outstanding", q.size(), 2);
    br_valid = 1'b1; BS = 2'b10; PS = 1'b0; Z = 1'b0; br_target = 32'h80;
    cycle();
    chk("t5_no_req_redirect", last_reqv, 0);
    br_valid = 1'b0;
    wait_fire(20, n);
    chk("t5_cycles_to_target", n, 3);
    chk("t5_target_addr", last_addr, 32'h80);
    repeat (8) cycle();

    // Reset while flushing returns to reset state and refetches from RESET_PC.
    do_reset(2); lat = 3; n = 0;
    while (q.size() < 2 && n < 20) begin cycle(); n++; end
    br_valid = 1'b1; BS = 2'b11; br_target = 32'h90;
    cycle();
    br_valid = 1'b0;
    cycle();
    do_reset(2); lat = 1;
    cycle();
    chk("t6_req_after_rst", last_rfire, 1);
    chk("t6_addr", last_addr, RPC);
    repeat (6) cycle();

    // Randomized traffic checked against the model.
    delivered = 0;
    for (int seg = 0; seg < 6; seg++) begin
      do_reset(2);
      lat = 1 + seg % 4;
      gap_pct = (seg * 7) % 30;
      for (int c = 0; c < 500; c++) begin
        instr_ready    = ($urandom_range(99) < 75);
        imem_req_ready = ($urandom_range(99) < 85);
        br_valid       = ($urandom_range(99) < 6);
        BS             = 2'($urandom_range(3));
        PS             = 1'($urandom_range(1));
        Z              = 1'($urandom_range(1));
        br_target      = ($urandom_range(9) == 0) ? 32'hFFFF_FFFE : $urandom();
        cycle();
      end
      delivered += exp_fetch;
    end
    chk("random_progress", delivered > 300, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
